// File: rtl/sm_imem_loader_pkg.sv
// Shared types for the schoolRISCV instruction-memory boot loader: FSM states,
// frame field widths and the RAM write payload.
package sm_imem_loader_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [2:0] {
      ST_SYNC   = 3'd0,
      ST_CNT_LO = 3'd1,
      ST_CNT_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_RUN    = 3'd5,
      ST_ERR    = 3'd6
   } state_e;

   typedef struct packed {
      logic [WORD_W-1:0] a;
      logic [WORD_W-1:0] wd;
   } imem_wr_t;

   // States between the sync byte and the checksum byte
   function automatic logic in_frame(input state_e s);
      return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/sm_imem_loader_timeout.sv
// Idle watchdog for the frame parser: expire_o goes high for the cycle in which
// the TIMEOUT-th consecutive idle cycle is being sampled.
module sm_imem_loader_timeout #(
   parameter int unsigned TIMEOUT = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q;
   logic          expire_q;

   // Expire is registered one count early so it lines up with the final idle edge
   always_ff @(posedge clk) begin
      if (rst || clr_i || !en_i) begin
         cnt_q    <= '0;
         expire_q <= 1'b0;
      end else begin
         if (cnt_q != CW'(TIMEOUT - 1)) begin
            cnt_q <= cnt_q + CW'(1);
         end
         expire_q <= (cnt_q == CW'(TIMEOUT - 2));
      end
   end

   assign expire_o = expire_q;

endmodule

// File: rtl/sm_imem_loader.sv
// Boot loader: parses a framed byte stream into little-endian words, writes them to
// instruction RAM and releases the CPU reset once the frame checksum matches.
module sm_imem_loader
   import sm_imem_loader_pkg::*;
#(
   parameter int unsigned SIZE      = 64,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned TIMEOUT   = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        boot_req,
   output logic        imem_we,
   output logic [31:0] imem_a,
   output logic [31:0] imem_wd,
   output logic        cpu_rst,
   output logic        busy,
   output logic        done,
   output logic        err
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  idx_q;
   logic [1:0]        lane_q;
   logic [23:0]       asm_q;
   logic [BYTE_W-1:0] xor_q;
   imem_wr_t          wr_q;
   logic              we_q;
   logic              cpu_rst_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic              expire;
   logic [CNT_W-1:0]  cnt_full;
   logic              last_word;

   assign cnt_full  = {rx_data, cnt_q[7:0]};
   assign last_word = (lane_q == 2'd3) && (idx_q == cnt_q - CNT_W'(1));

   sm_imem_loader_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (rx_valid),
      .en_i     (in_frame(state_q)),
      .expire_o (expire)
   );

   // Next-state logic; boot_req has priority over a byte in RUN/ERR
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_SYNC: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) state_d = ST_CNT_LO;
         end
         ST_CNT_LO: begin
            if (rx_valid) state_d = ST_CNT_HI;
         end
         ST_CNT_HI: begin
            if (rx_valid) begin
               if (32'(cnt_full) > SIZE)        state_d = ST_ERR;
               else if (cnt_full == '0)         state_d = ST_CSUM;
               else                             state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_valid && last_word) state_d = ST_CSUM;
         end
         ST_CSUM: begin
            if (rx_valid) state_d = (rx_data == xor_q) ? ST_RUN : ST_ERR;
         end
         ST_RUN: begin
            if (boot_req) state_d = ST_SYNC;
         end
         ST_ERR: begin
            if (boot_req)                                   state_d = ST_SYNC;
            else if (rx_valid && (rx_data == SYNC_BYTE))    state_d = ST_CNT_LO;
         end
         default: state_d = ST_SYNC;
      endcase
      if (in_frame(state_q) && !rx_valid && expire) state_d = ST_ERR;
   end

   // State, datapath and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_SYNC;
         cnt_q     <= '0;
         idx_q     <= '0;
         lane_q    <= '0;
         asm_q     <= '0;
         xor_q     <= '0;
         wr_q      <= '0;
         we_q      <= 1'b0;
         cpu_rst_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         we_q      <= 1'b0;
         cpu_rst_q <= (state_d != ST_RUN);
         done_q    <= (state_d == ST_RUN);
         busy_q    <= in_frame(state_d);

         if (state_d == ST_ERR) begin
            err_q <= 1'b1;
         end else if ((state_d == ST_CNT_LO) && !in_frame(state_q)) begin
            err_q <= 1'b0;
         end

         if (rx_valid) begin
            unique case (state_q)
               ST_CNT_LO: cnt_q[7:0] <= rx_data;
               ST_CNT_HI: begin
                  cnt_q[15:8] <= rx_data;
                  idx_q       <= '0;
                  lane_q      <= '0;
                  xor_q       <= '0;
               end
               ST_DATA: begin
                  xor_q  <= xor_q ^ rx_data;
                  lane_q <= lane_q + 2'd1;
                  unique case (lane_q)
                     2'd0: asm_q[7:0]   <= rx_data;
                     2'd1: asm_q[15:8]  <= rx_data;
                     2'd2: asm_q[23:16] <= rx_data;
                     default: begin
                        wr_q.a  <= 32'(idx_q);
                        wr_q.wd <= {rx_data, asm_q};
                        we_q    <= 1'b1;
                        idx_q   <= idx_q + CNT_W'(1);
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   assign imem_we = we_q;
   assign imem_a  = wr_q.a;
   assign imem_wd = wr_q.wd;
   assign cpu_rst = cpu_rst_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule
